// File: rtl/simon_codec_if.sv
// Simon codec bus: key load, block in and block out handshakes.
// Ports: key_valid/key_ready/key/key_loaded, in_valid/in_ready/decrypt/data_in,
//        out_valid/out_ready/data_out, busy.
interface simon_codec_if #(
  parameter int N = 16,
  parameter int M = 4
) ();
  logic           key_valid;
  logic           key_ready;
  logic [N*M-1:0] key;
  logic           key_loaded;
  logic           in_valid;
  logic           in_ready;
  logic           decrypt;
  logic [2*N-1:0] data_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] data_out;
  logic           busy;

  modport slave (
    input  key_valid,
    input  key,
    input  in_valid,
    input  decrypt,
    input  data_in,
    input  out_ready,
    output key_ready,
    output key_loaded,
    output in_ready,
    output out_valid,
    output data_out,
    output busy
  );

  modport master (
    output key_valid,
    output key,
    output in_valid,
    output decrypt,
    output data_in,
    output out_ready,
    input  key_ready,
    input  key_loaded,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  busy
  );
endinterface

// File: rtl/simon_codec.sv
// Simon block cipher engine, encrypt/decrypt, one round per clock.
// Ports: clk, rst (sync, active high), io (simon_codec_if.slave): key load,
//        block in with decrypt select, block out with backpressure, busy.
module simon_codec #(
  parameter int N    = 16,
  parameter int M    = 4,
  parameter int T    = 32,
  parameter int ZSEQ = 0
) (
  input  logic         clk,
  input  logic         rst,
  simon_codec_if.slave io
);

  localparam int CW = $clog2(T + 1);
  localparam int AW = (T > 1) ? $clog2(T) : 1;
  localparam bit NOEXP = (T == M);

  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 =
    62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 =
    62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 =
    62'b11010001111001101011011000100000010111000011001010010011101111;

  // z[j] is the j-th symbol from the left, i.e. bit 61-j
  localparam logic [61:0] ZC =
    (ZSEQ == 0) ? Z0 :
    (ZSEQ == 1) ? Z1 :
    (ZSEQ == 2) ? Z2 :
    (ZSEQ == 3) ? Z3 : Z4;

  typedef enum logic [2:0] {
    NOKEY,
    EXPAND,
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t state;
  state_t state_n;

  logic [N-1:0]  rk [T];
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic          dec;
  logic [CW-1:0] ctr;
  logic          loaded;

  logic          key_go;
  logic          blk_go;
  logic          exp_last;
  logic          run_last;
  logic [N-1:0]  tmp;
  logic [N-1:0]  rk_new;
  logic          zb;
  logic [AW-1:0] kidx;
  logic [N-1:0]  rkey;
  logic [N-1:0]  x_n;
  logic [N-1:0]  y_n;

  function automatic logic [N-1:0] rol(
    input logic [N-1:0] v,
    input int           s
  );
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(
    input logic [N-1:0] v,
    input int           s
  );
    return rol(v, N - s);
  endfunction

  function automatic logic [N-1:0] sf(
    input logic [N-1:0] v
  );
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  assign exp_last = NOEXP || (ctr == CW'(T - 1));
  assign run_last = (ctr == CW'(T - 1));

  always_comb begin
    state_n = state;
    key_go  = 1'b0;
    blk_go  = 1'b0;
    unique case (state)
      NOKEY: begin
        if (io.key_valid) begin
          key_go  = 1'b1;
          state_n = EXPAND;
        end
      end
      EXPAND: begin
        if (exp_last) state_n = IDLE;
      end
      IDLE: begin
        // a key offer wins over a block offer
        if (io.key_valid) begin
          key_go  = 1'b1;
          state_n = EXPAND;
        end else if (io.in_valid) begin
          blk_go  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (run_last) state_n = HOLD;
      end
      HOLD: begin
        if (io.out_ready) state_n = IDLE;
      end
      default: state_n = NOKEY;
    endcase
  end

  always_comb begin
    tmp = ror(rk[AW'(ctr - 1)], 3);
    if (M == 4) tmp = tmp ^ rk[AW'(ctr - 3)];
    tmp = tmp ^ ror(tmp, 1);
    zb  = ZC[6'(61 - ((int'(ctr) - M) % 62))];
    rk_new = ~rk[AW'(ctr - M)] ^ tmp
           ^ {{(N-1){1'b0}}, zb} ^ N'(3);
  end

  always_comb begin
    kidx = dec ? AW'(T - 1 - int'(ctr)) : AW'(ctr);
    rkey = rk[kidx];
    if (dec) begin
      x_n = y;
      y_n = x ^ sf(y) ^ rkey;
    end else begin
      x_n = y ^ sf(x) ^ rkey;
      y_n = x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= NOKEY;
      x      <= '0;
      y      <= '0;
      dec    <= 1'b0;
      ctr    <= '0;
      loaded <= 1'b0;
    end else begin
      state <= state_n;
      if (key_go) begin
        loaded <= 1'b0;
        ctr    <= CW'(M);
      end
      if (state == EXPAND) begin
        ctr <= ctr + 1'b1;
        if (exp_last) loaded <= 1'b1;
      end
      if (blk_go) begin
        x   <= io.data_in[2*N-1:N];
        y   <= io.data_in[N-1:0];
        dec <= io.decrypt;
        ctr <= '0;
      end
      if (state == RUN) begin
        x   <= x_n;
        y   <= y_n;
        ctr <= ctr + 1'b1;
      end
    end
  end

  // round-key store carries no reset; key_loaded guards its use
  always_ff @(posedge clk) begin
    if (key_go) begin
      for (int i = 0; i < M; i++)
        rk[AW'(i)] <= io.key[N*i +: N];
    end
    if (!NOEXP && state == EXPAND)
      rk[AW'(ctr)] <= rk_new;
  end

  assign io.key_ready  = (state == NOKEY)
                      || (state == IDLE);
  assign io.key_loaded = loaded;
  // a simultaneous key offer takes the IDLE slot
  assign io.in_ready   = (state == IDLE)
                      && !io.key_valid;
  assign io.out_valid  = (state == HOLD);
  assign io.data_out   = {x, y};
  assign io.busy       = (state == EXPAND)
                      || (state == RUN);

endmodule

// File: tb/tb_simon_codec.sv
// Self-checking bench for simon_codec: two configurations,
// known vectors, randomized blocks against a reference model.
module tb_simon_codec;

  logic clk;
  logic rst;

  simon_codec_if #(.N(16), .M(4)) ia ();
  simon_codec_if #(.N(32), .M(4)) ib ();

  simon_codec #(.N(16), .M(4), .T(32), .ZSEQ(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .io  (ia)
  );

  simon_codec #(.N(32), .M(4), .T(44), .ZSEQ(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .io  (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  longint unsigned mrk [72];

  string zstr [5] = '{
    "11111010001001010110000111001101111101000100101011000011100110",
    "10001110111110010011000010110101000111011111001001100001011010",
    "10101111011100000011010010011000101000010001111110010110110011",
    "11011011101011000110010111100000010010001010011100110100001111",
    "11010001111001101011011000100000010111000011001010010011101111"
  };

  localparam logic [63:0]  KA = 64'h1918111009080100;
  localparam logic [31:0]  PA = 32'h65656877;
  localparam logic [31:0]  CA = 32'hc69be9bb;
  localparam logic [127:0] KB =
    128'h1b1a1918131211100b0a090803020100;
  localparam logic [63:0]  PB = 64'h656b696c20646e75;
  localparam logic [63:0]  CB = 64'h44c8fc20b9dfa07a;

  task automatic chk(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic longint unsigned rotl(
    longint unsigned v, int s, int n
  );
    longint unsigned msk = (64'd1 << n) - 1;
    v = v & msk;
    return ((v << s) | (v >> (n - s))) & msk;
  endfunction

  function automatic longint unsigned sf(
    longint unsigned v, int n
  );
    return (rotl(v, 1, n) & rotl(v, 8, n)) ^ rotl(v, 2, n);
  endfunction

  task automatic model_keys(
    input int n, input int m, input int t, input int zi,
    input logic [127:0] key
  );
    longint unsigned msk = (64'd1 << n) - 1;
    longint unsigned c = msk ^ 64'd3;
    longint unsigned tv;
    longint unsigned zb;
    string zs = zstr[zi];
    for (int i = 0; i < m; i++)
      mrk[i] = 64'(key >> (n * i)) & msk;
    for (int i = m; i < t; i++) begin
      tv = rotl(mrk[i-1], n - 3, n);
      if (m == 4) tv = tv ^ mrk[i-3];
      tv = tv ^ rotl(tv, n - 1, n);
      zb = (zs[(i - m) % 62] == "1") ? 64'd1 : 64'd0;
      mrk[i] = c ^ zb ^ mrk[i-m] ^ tv;
    end
  endtask

  function automatic longint unsigned model_crypt(
    int n, int t, bit d, longint unsigned blk
  );
    longint unsigned msk = (64'd1 << n) - 1;
    longint unsigned x = (blk >> n) & msk;
    longint unsigned y = blk & msk;
    longint unsigned tv;
    for (int r = 0; r < t; r++) begin
      if (!d) begin
        tv = x;
        x = y ^ sf(x, n) ^ mrk[r];
        y = tv;
      end else begin
        tv = y;
        y = x ^ sf(y, n) ^ mrk[t-1-r];
        x = tv;
      end
    end
    return (x << n) | y;
  endfunction

  task automatic load_key_a(input logic [63:0] k);
    int cyc = 0;
    while (!ia.key_ready && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("a_key_ready", 64'(ia.key_ready), 64'd1);
    ia.key = k;
    ia.key_valid = 1'b1;
    @(posedge clk); #1;
    ia.key_valid = 1'b0;
    chk("a_kl_clear", 64'(ia.key_loaded), 64'd0);
    chk("a_busy_exp", 64'(ia.busy), 64'd1);
    cyc = 0;
    while (!ia.key_loaded && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("a_expand_cycles", 64'(cyc), 64'd28);
    chk("a_idle_busy", 64'(ia.busy), 64'd0);
    model_keys(16, 4, 32, 0, {64'd0, k});
  endtask

  task automatic blk_a(
    input bit          d,
    input logic [31:0] din,
    input int          hold,
    output logic [31:0] got
  );
    int cyc = 0;
    bit bad_h = 1'b0;
    bit bad_r = 1'b0;
    logic [31:0] exp;
    exp = 32'(model_crypt(16, 32, d, {32'd0, din}));
    while (!ia.in_ready && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("a_in_ready", 64'(ia.in_ready), 64'd1);
    ia.decrypt = d;
    ia.data_in = din;
    ia.in_valid = 1'b1;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    ia.data_in = $urandom;
    ia.decrypt = 1'($urandom);
    chk("a_busy_run", 64'(ia.busy), 64'd1);
    cyc = 0;
    while (!ia.out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("a_latency", 64'(cyc), 64'd32);
    got = ia.data_out;
    chk("a_data", 64'(got), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      ia.key = {$urandom, $urandom};
      ia.key_valid = 1'b1;
      if (ia.key_ready || ia.in_ready) bad_r = 1'b1;
      @(posedge clk); #1;
      if (!ia.out_valid || ia.data_out !== got)
        bad_h = 1'b1;
    end
    ia.key_valid = 1'b0;
    if (hold > 0) begin
      chk("a_hold_stable", 64'(bad_h), 64'd0);
      chk("a_hold_ready", 64'(bad_r), 64'd0);
    end
    chk("a_hold_in_ready", 64'(ia.in_ready), 64'd0);
    ia.out_ready = 1'b1;
    @(posedge clk); #1;
    ia.out_ready = 1'b0;
    chk("a_ov_drop", 64'(ia.out_valid), 64'd0);
    chk("a_next_ready", 64'(ia.in_ready), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] ct;
    logic [31:0] pt;
    logic [63:0] exp64;
    int cyc;
    int nres;
    int last;
    bit seen_r;
    bit seen_v;

    rst = 1'b1;
    ia.key_valid = 1'b0; ia.key = '0;
    ia.in_valid = 1'b0; ia.decrypt = 1'b0;
    ia.data_in = '0; ia.out_ready = 1'b0;
    ib.key_valid = 1'b0; ib.key = '0;
    ib.in_valid = 1'b0; ib.decrypt = 1'b0;
    ib.data_in = '0; ib.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_key_ready", 64'(ia.key_ready), 64'd1);
    chk("rst_key_loaded", 64'(ia.key_loaded), 64'd0);
    chk("rst_in_ready", 64'(ia.in_ready), 64'd0);
    chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
    chk("rst_data_out", 64'(ia.data_out), 64'd0);
    chk("rst_busy", 64'(ia.busy), 64'd0);
    chk("rst_b_key_ready", 64'(ib.key_ready), 64'd1);

    // block offered before any key
    ia.in_valid = 1'b1;
    ia.data_in = PA;
    seen_r = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ia.in_ready) seen_r = 1'b1;
      @(posedge clk); #1;
      if (ia.out_valid || ia.busy) seen_v = 1'b1;
    end
    ia.in_valid = 1'b0;
    chk("nokey_in_ready", 64'(seen_r), 64'd0);
    chk("nokey_out_valid", 64'(seen_v), 64'd0);

    // wide configuration, back-to-back blocks
    model_keys(32, 4, 44, 3, KB);
    ib.key = KB;
    ib.key_valid = 1'b1;
    @(posedge clk); #1;
    ib.key_valid = 1'b0;
    cyc = 0;
    while (!ib.key_loaded && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("b_expand_cycles", 64'(cyc), 64'd40);
    exp64 = 64'(model_crypt(32, 44, 1'b0, PB));
    chk("b_model_vec", exp64, CB);
    ib.data_in = PB;
    ib.decrypt = 1'b0;
    ib.in_valid = 1'b1;
    ib.out_ready = 1'b1;
    nres = 0;
    last = -1;
    cyc = 0;
    while (nres < 3 && cyc < 400) begin
      @(posedge clk); #1; cyc++;
      if (ib.out_valid) begin
        chk("b_ct", ib.data_out, CB);
        if (last >= 0)
          chk("b_period", 64'(cyc - last), 64'd46);
        last = cyc;
        nres++;
      end
    end
    chk("b_results", 64'(nres), 64'd3);
    ib.in_valid = 1'b0;
    ib.out_ready = 1'b0;

    // narrow configuration, known vectors
    load_key_a(KA);
    blk_a(1'b0, PA, 0, got);
    chk("a_vec_enc", 64'(got), 64'(CA));
    blk_a(1'b1, CA, 10, got);
    chk("a_vec_dec", 64'(got), 64'(PA));

    // randomized blocks and round trips
    for (int k = 0; k < 3; k++) begin
      if (k > 0) load_key_a({$urandom, $urandom});
      for (int b = 0; b < 4; b++) begin
        pt = $urandom;
        blk_a(1'b0, pt, int'($urandom_range(0, 3)), ct);
        blk_a(1'b1, ct, int'($urandom_range(0, 3)), got);
        chk("a_round_trip", 64'(got), 64'(pt));
      end
    end

    // reset in the middle of a run
    load_key_a(KA);
    ia.data_in = PA;
    ia.decrypt = 1'b0;
    ia.in_valid = 1'b1;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", 64'(ia.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 64'(ia.out_valid), 64'd0);
    chk("mid_rst_key_loaded", 64'(ia.key_loaded), 64'd0);
    chk("mid_rst_key_ready", 64'(ia.key_ready), 64'd1);
    chk("mid_rst_busy", 64'(ia.busy), 64'd0);
    chk("mid_rst_in_ready", 64'(ia.in_ready), 64'd0);
    chk("mid_rst_data", 64'(ia.data_out), 64'd0);

    load_key_a(KA);
    blk_a(1'b0, PA, 2, got);
    chk("a_vec_after_rst", 64'(got), 64'(CA));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
